// File: rtl/sv_uart_rx_packer.sv
// sv_uart_rx_packer: packs received UART bytes MSB-first into words, with backpressure and an inter-byte timeout
module sv_uart_rx_packer #(
  parameter int DATA_WIDTH   = 24,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [15:0]           idivider,
  output logic                  odrop,
  output logic [15:0]           odrop_cnt
);
  localparam int WORDS_NUM = DATA_WIDTH / 8;
  localparam int CW = $clog2(WORDS_NUM);
  localparam int TW = $clog2(TIMEOUT_BITS + 2);
  localparam logic [CW-1:0] LAST = CW'(WORDS_NUM - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_BITS);
  logic [CW-1:0] byte_cnt, byte_cnt_nxt;
  logic [CW+2:0] shamt;
  logic [DATA_WIDTH-1:0] asm_q, asm_nxt;
  logic [15:0] presc, div_m1;
  logic [TW-1:0] tmo_cnt;
  logic fill, last_byte, accept, load, bit_tick, timeout;
  // state-derived outputs: ready drops only when the final byte would have nowhere to go
  always_comb begin
    fill = byte_cnt != '0;
    last_byte = byte_cnt == LAST;
    s_axis_tready = !(last_byte && m_axis_tvalid);
  end
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign load     = accept && last_byte;
  assign div_m1   = (idivider == 16'd0) ? 16'd0 : idivider - 16'd1;
  assign bit_tick = fill && presc >= div_m1;
  assign timeout  = (TIMEOUT_BITS != 0) && fill && tmo_cnt == TMO_MAX && !accept;
  assign shamt    = {LAST - byte_cnt, 3'b000};
  assign asm_nxt  = asm_q | (DATA_WIDTH'(s_axis_tdata) << shamt);
  // next byte position: an accepted byte always beats a simultaneous timeout
  always_comb begin
    byte_cnt_nxt = accept ? (last_byte ? '0 : byte_cnt + CW'(1)) : (timeout ? '0 : byte_cnt);
  end
  // byte position register (IDLE when zero, FILL otherwise)
  always_ff @(posedge iclk) begin
    byte_cnt <= irst ? '0 : byte_cnt_nxt;
  end
  // partial word, cleared when complete, stale or reset
  always_ff @(posedge iclk) begin
    if (irst || timeout || load) asm_q <= '0;
    else if (accept) asm_q <= asm_nxt;
  end
  // output word register, held until the downstream handshake
  always_ff @(posedge iclk) begin
    if (irst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      m_axis_tvalid <= load || (m_axis_tvalid && !m_axis_tready);
      if (load) m_axis_tdata <= asm_nxt;
    end
  end
  // bit-period prescaler, restarted by each byte and idle outside FILL
  always_ff @(posedge iclk) begin
    if (irst || accept || !fill || bit_tick) presc <= '0;
    else presc <= presc + 16'd1;
  end
  // idle bit-period counter, saturating at the timeout threshold
  always_ff @(posedge iclk) begin
    if (irst || accept || !fill || timeout) tmo_cnt <= '0;
    else if (bit_tick && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
  end
  // drop pulse and saturating drop counter
  always_ff @(posedge iclk) begin
    if (irst) begin
      odrop     <= 1'b0;
      odrop_cnt <= '0;
    end else begin
      odrop <= timeout;
      if (timeout && odrop_cnt != 16'hFFFF) odrop_cnt <= odrop_cnt + 16'd1;
    end
  end
endmodule
